// File: rtl/pma_pkg.sv
// ============================================================================
// Module : pma_pkg
// Brief  : Shared types and constants for the 100BASE-X PMA sublayer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pma_pkg;

    // Link monitor states; the encoding is visible on waveforms, so keep it fixed.
    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_HYST = 2'd1,
        ST_UP   = 2'd2
    } link_state_t;

    localparam logic [1:0] c_VALID_NONE = 2'd0;
    localparam logic [1:0] c_VALID_ONE  = 2'd1;

endpackage : pma_pkg

`default_nettype wire

// File: rtl/pma_link_monitor.sv
// ============================================================================
// Module : pma_link_monitor
// Brief  : signal_status synchronizer plus debounce FSM producing link_status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pma_link_monitor
    import pma_pkg::*;
#(
    parameter int LINK_TIME   = 41250,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_signal_status,
    output logic o_link_status
);

    localparam int TW = $clog2(LINK_TIME + 1);
    localparam logic [TW-1:0] c_TIMER_LOAD = TW'(LINK_TIME - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sig_s;

    link_state_t r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_link, w_link_nxt;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= i_signal_status;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal_status};
            end
        end
    endgenerate

    assign w_sig_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DOWN;
            r_timer <= '0;
            r_link  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_link  <= w_link_nxt;
        end
    end

    // link_status is registered alongside the state so both change on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_link_nxt  = r_link;
        case (r_state)
            ST_DOWN: begin
                w_link_nxt = 1'b0;
                if (w_sig_s) begin
                    w_state_nxt = ST_HYST;
                    w_timer_nxt = c_TIMER_LOAD;
                end
            end
            ST_HYST: begin
                if (!w_sig_s) begin
                    w_state_nxt = ST_DOWN;
                    w_link_nxt  = 1'b0;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_UP;
                    w_link_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_UP: begin
                w_link_nxt = 1'b1;
                if (!w_sig_s) begin
                    w_state_nxt = ST_DOWN;
                    w_link_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_DOWN;
                w_link_nxt  = 1'b0;
            end
        endcase
    end

    assign o_link_status = r_link;

endmodule : pma_link_monitor

`default_nettype wire

// File: rtl/pma.sv
// ============================================================================
// Module : pma
// Brief  : 100BASE-X PMA: NRZI TX encode, NRZI RX decode and link monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pma
    import pma_pkg::*;
#(
    parameter int LINK_TIME   = 41250,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pma_data_tx,
    output logic       pmd_data_tx,
    input  logic [1:0] pmd_data_rx,
    input  logic [1:0] pmd_data_rx_valid,
    input  logic       signal_status,
    output logic [1:0] pma_data_rx,
    output logic [1:0] pma_data_rx_valid,
    output logic       link_status
);

    logic       r_tx_level;
    logic       r_rx_last;
    logic [1:0] r_rx_data;
    logic [1:0] r_rx_valid;

    always_ff @(posedge clk) begin
        if (rst) r_tx_level <= 1'b0;
        else     r_tx_level <= r_tx_level ^ pma_data_tx;
    end

    // Each NRZ bit is the XOR of a line bit with the line level before it; [1] is oldest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_last  <= 1'b0;
            r_rx_data  <= 2'b00;
            r_rx_valid <= 2'b00;
        end else begin
            r_rx_valid <= pmd_data_rx_valid;
            case (pmd_data_rx_valid)
                c_VALID_NONE: begin
                    r_rx_data <= 2'b00;
                end
                c_VALID_ONE: begin
                    r_rx_data <= {pmd_data_rx[1] ^ r_rx_last, 1'b0};
                    r_rx_last <= pmd_data_rx[1];
                end
                default: begin
                    r_rx_data <= {pmd_data_rx[1] ^ r_rx_last,
                                  pmd_data_rx[0] ^ pmd_data_rx[1]};
                    r_rx_last <= pmd_data_rx[0];
                end
            endcase
        end
    end

    pma_link_monitor #(
        .LINK_TIME   (LINK_TIME),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_link_monitor (
        .clk             (clk),
        .rst             (rst),
        .i_signal_status (signal_status),
        .o_link_status   (link_status)
    );

    assign pmd_data_tx       = r_tx_level;
    assign pma_data_rx       = r_rx_data;
    assign pma_data_rx_valid = r_rx_valid;

endmodule : pma

`default_nettype wire
